// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the pipeline hazard controller (forward selects, shadow slots, redirect FSM).
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10,
        FWD_RET = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } slot_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_t;

    localparam slot_t BUBBLE = '0;

    // x0 is hardwired zero, so a write to it can never feed a consumer.
    function automatic logic slot_hit(slot_t s, logic use_rs, logic [4:0] rs);
        return s.valid && s.wr && use_rs && (rs != 5'd0) && (s.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one decode source against the ex/mem/wb shadow slots, youngest producer first.
module hazard_match
    import pipe_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       use_i,
    input  slot_t      ex_i,
    input  slot_t      mem_i,
    input  slot_t      wb_i,
    output logic       hit_o,
    output logic       load_hit_o,
    output fwd_sel_t   fwd_o
);
    logic h_ex, h_mem, h_wb;
    logic unused_ld;

    assign h_ex       = slot_hit(ex_i, use_i, rs_i);
    assign h_mem      = slot_hit(mem_i, use_i, rs_i);
    assign h_wb       = slot_hit(wb_i, use_i, rs_i);
    assign hit_o      = h_ex | h_mem | h_wb;
    assign load_hit_o = h_ex & ex_i.load;
    assign fwd_o      = h_ex ? FWD_MEM : h_mem ? FWD_WB : h_wb ? FWD_RET : FWD_RF;
    assign unused_ld  = mem_i.load ^ wb_i.load;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the five-stage core, with stall and flush event counters.
// Define FORWARD_EN to resolve non-load hazards through registered forward selects instead of stalling.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);

    slot_t            ex_q, mem_q, wb_q, ex_d;
    ctrl_state_t      state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             hit_a, hit_b, ld_a, ld_b, hazard, issue;
    fwd_sel_t         sel_a, sel_b;

    hazard_match u_match_a (
        .rs_i       (id_rs1),
        .use_i      (id_use_rs1),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .hit_o      (hit_a),
        .load_hit_o (ld_a),
        .fwd_o      (sel_a)
    );

    hazard_match u_match_b (
        .rs_i       (id_rs2),
        .use_i      (id_use_rs2),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .hit_o      (hit_b),
        .load_hit_o (ld_b),
        .fwd_o      (sel_b)
    );

    // Gating with rst keeps flush low for the whole reset window, even if a redirect is pending.
    assign flush       = rst && (ex_redirect || state_q == FLUSH);
    assign stall       = hazard && !flush;
    assign issue       = id_valid && !stall && !flush;
    assign ex_d        = issue ? slot_t'{1'b1, id_rd, id_wr_en, id_is_load} : BUBBLE;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ex_redirect && FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = RELOAD;
        end else if (state_q == FLUSH) begin
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_q == 3'd1) ? RUN : FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= BUBBLE;
            mem_q       <= BUBBLE;
            wb_q        <= BUBBLE;
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
            flush_cnt_q <= flush_cnt_q + CNT_W'(flush);
        end
    end

`ifdef FORWARD_EN
    fwd_sel_t fwd_a_q, fwd_b_q;
    logic     unused_hit;

    // Only a load sitting in execute cannot be bypassed; everything else forwards.
    assign hazard     = ld_a | ld_b;
    assign fwd_a      = fwd_a_q;
    assign fwd_b      = fwd_b_q;
    assign unused_hit = hit_a ^ hit_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= issue ? sel_a : FWD_RF;
            fwd_b_q <= issue ? sel_b : FWD_RF;
        end
    end
`else
    logic unused_fwd;

    assign hazard     = hit_a | hit_b;
    assign fwd_a      = FWD_RF;
    assign fwd_b      = FWD_RF;
    assign unused_fwd = ^{sel_a, sel_b, ld_a, ld_b};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl; expected outputs are queued per cycle and checked by a monitor.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wr_en = 1'b0, id_is_load = 1'b0;
    logic        ex_redirect = 1'b0;
    logic        stall, flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_count, flush_count;

    typedef struct {
        logic       s;
        logic       f;
        logic [1:0] fa;
        logic [1:0] fb;
        int         sc;
        int         fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   esc = 0;
    int   efc = 0;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_wr_en    (id_wr_en),
        .id_is_load  (id_is_load),
        .ex_redirect (ex_redirect),
        .stall       (stall),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall", stall, e.s);
            chk("flush", flush, e.f);
            chk("fwd_a", fwd_a, e.fa);
            chk("fwd_b", fwd_b, e.fb);
            chk("stall_count", stall_count, e.sc);
            chk("flush_count", flush_count, e.fc);
        end
    end

    task automatic expect_now(input logic es, input logic ef, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.s  = es;
        e.f  = ef;
        e.fa = fa;
        e.fb = fb;
        e.sc = esc;
        e.fc = efc;
        q.push_back(e);
        esc += int'(es);
        efc += int'(ef);
    endtask

    task automatic cyc(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic rdr,
                       input logic es, input logic ef, input logic [1:0] fa, input logic [1:0] fb);
        @(posedge clk);
        #1;
        id_valid    = v;
        id_rs1      = r1;
        id_rs2      = r2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_rd       = rd;
        id_wr_en    = wr;
        id_is_load  = ld;
        ex_redirect = rdr;
        expect_now(es, ef, fa, fb);
    endtask

    task automatic nop(input logic [1:0] fa, input logic [1:0] fb);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // reset state
        nop(0, 0);
        nop(0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        nop(0, 0);
`ifdef FORWARD_EN
        // back-to-back x5 -> x6: forwarded from memory stage, no stall
        cyc(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 5, 3, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        nop(1, 0);
        nop(0, 0);
        nop(0, 0);
        // load-use on x7: one stall, then writeback forward
        cyc(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0);
        nop(2, 0);
        nop(0, 0);
        nop(0, 0);
        // distance-3 producer of x9 on rs2
        cyc(1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 9, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 3);
        nop(0, 0);
        nop(0, 0);
`else
        // back-to-back x5 -> x6: three stall cycles
        cyc(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 5, 3, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 5, 3, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 5, 3, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 5, 3, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 0);
        nop(0, 0);
        nop(0, 0);
        // load-use on x7 without forwarding also waits for writeback to clear
        cyc(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 0);
        nop(0, 0);
        nop(0, 0);
        // distance-3 producer of x9 on rs2: one stall
        cyc(1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 9, 1, 1, 12, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 9, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 0);
        nop(0, 0);
        nop(0, 0);
`endif
        // x0 producer/consumer and an unused matching rs2
        cyc(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 1, 1, 13, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 13, 1, 0, 14, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 0);
        nop(0, 0);
        nop(0, 0);
        // redirect during a load-use stall: flush wins for two cycles, consumer never reaches execute
        cyc(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 1, 0, 1, 0, 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, 1, 0, 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 0);
        nop(0, 0);
        nop(0, 0);
        // asynchronous reset in the middle of a flush window
        cyc(1, 1, 0, 1, 0, 20, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        ex_redirect = 1'b0;
        rst         = 1'b0;
        esc         = 0;
        efc         = 0;
        expect_now(0, 0, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        cyc(1, 20, 0, 1, 0, 21, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core (fetch, decode, execute, memory, writeback). It shadows the destination register of every in-flight instruction and compares it with the sources of the instruction being decoded. From that it drives a fetch/decode stall, a pipeline flush on taken jumps, and forwarding selects registered into the execute stage. It also keeps stall and flush event counters for bring-up.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles flush stays asserted per redirect; range 1..7.
- CNT_W, 32: width of the event counters.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1, id_rs2  in  5  source register numbers of the decoding instruction.
- id_use_rs1, id_use_rs2  in  1  the instruction actually reads that source.
- id_rd  in  5  destination register of the decoding instruction.
- id_wr_en  in  1  the decoding instruction writes id_rd.
- id_is_load  in  1  the decoding instruction is a load (result available only after memory).
- ex_redirect  in  1  execute resolved a taken jump/branch this cycle.
- stall  out  1  hold the fetch PC and decode inputs; decode issues a bubble.
- flush  out  1  drive decode flush; discard the fetched instruction.
- fwd_a, fwd_b  out  2  execute-stage operand source: 00 regfile, 01 memory-stage result, 10 writeback data, 11 retired-data register.
- stall_count, flush_count  out  CNT_W  cycles with stall / flush high.

## Operation
- Shadow slots ex_s, mem_s and wb_s each hold {valid, rd, wr, load}. Every cycle: wb_s <= mem_s, mem_s <= ex_s.
- ex_s <= id fields when id_valid && !stall && !flush; otherwise ex_s <= bubble (valid=0).
- A slot matches source rsN when: slot valid, slot wr set, id_use_rsN set, rsN != 0, and slot rd == rsN.
- Redirect FSM states:
  - RUN to FLUSH: on ex_redirect, load the counter with FLUSH_CYCLES-1.
  - FLUSH to RUN: when the counter reaches 0; the counter decrements each FLUSH cycle.
  - An ex_redirect during FLUSH reloads the counter.
  - With FLUSH_CYCLES=1, the FSM never leaves RUN.
- flush = ex_redirect || (state == FLUSH).
- stall = hazard && !flush. Flush has priority over stall.
- Counters increment by 1 on each cycle stall (respectively flush) is high. They wrap modulo 2^CNT_W.
- A write to x0 never creates a hazard.

## Timing
- stall and flush are combinational from the current inputs and registered state, so they are valid in the same cycle.
- fwd_a and fwd_b are registered. A select computed during decode in cycle N applies to execute in cycle N+1.
- fwd selects are forced to 00 when the instruction is a bubble.
- Forward priority is youngest producer first: ex_s (01), then mem_s (10), then wb_s (11).
- A producer in wb_s requires code 11 because the regfile write and the decode read happen on the same edge; the read returns the old value.
- Stall latency:
  - Load-use hazard: exactly 1 stall cycle.
  - Non-forwarding hazard: stall until no match remains, at most 3 cycles.
- Reset values: stall=0, flush=0, fwd_a=fwd_b=00, counters=0, all slots invalid, FSM in RUN.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

## Configuration
- FORWARD_EN defined:
  - hazard = match on ex_s with ex_s.load set (load-use).
  - All other matches are resolved through fwd_a and fwd_b.
- FORWARD_EN undefined:
  - hazard = any match on ex_s, mem_s or wb_s.
  - fwd_a and fwd_b are tied to 00 and the forwarding registers are not built.

## Structure
- Shared package pipe_pkg holds:
  - the fwd_sel_t enum (FWD_RF, FWD_MEM, FWD_WB, FWD_RET);
  - the slot_t struct {valid, rd, wr, load};
  - the ctrl_state_t enum (RUN, FLUSH).
- One sub-module, hazard_match: combinational comparison of one source against three slots. It returns hit and the fwd code, and is instantiated twice (rs1 and rs2).

## Test plan
- Back-to-back dependency: "add x5" followed by "add x6 using x5" → FORWARD_EN: stall never high, fwd_a=01 in the consumer's execute cycle. No FORWARD_EN: stall high for 3 cycles.
- Load-use: load x7, then "add using x7" → FORWARD_EN: stall for 1 cycle, then fwd_a=10. stall_count=1.
- Distance-3 producer: x9 written 3 instructions earlier → fwd_b=11 (FORWARD_EN) or 1 stall cycle (no FORWARD_EN).
- x0 and unused sources: producer writes x0 and consumer reads x0; id_use_rs2=0 with a matching rs2 → no stall, fwd=00.
- Redirect during load-use stall, FLUSH_CYCLES=2 → flush high for 2 cycles, stall 0 throughout, flush_count=2, ex_s bubble.
- Reset: assert rst asynchronously mid-FLUSH → flush=0 and counters=0 immediately. The first cycle after release is in RUN with no stall.
